fifo_wr_arbiter: RTL

Round-robin write arbiter sharing one `sync_fifo` write port among N producers. Each producer presents a request plus data. The arbiter grants one producer at a time for a bounded burst of up to BURST_MAX beats, and steers that producer's data into the FIFO. It stalls on FIFO full and rotates priority after every burst. It sits directly in front of `sync_fifo`, driving its `wr_i`/`din_i` and observing its `full_o`.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_N         = 4;
  localparam int ARB_WIDTH     = 16;
  localparam int ARB_BURST_MAX = 4;

  // Beat counter width; a single-beat burst still needs one bit.
  function automatic int cnt_width(input int burst_max);
    return (burst_max > 1) ? $clog2(burst_max) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set request at or above ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [PW:0]   sum;
  logic [PW-1:0] k;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap so non-power-of-two N never indexes past N-1.
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      k = sum[PW-1:0];
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers in bounded bursts.
//   state | meaning
//   IDLE  | no grant; arbitrate pending requests from rr_ptr
//   GRANT | grant_q owns the FIFO write port until release or BURST_MAX beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = ARB_N,
  parameter int WIDTH     = ARB_WIDTH,
  parameter int BURST_MAX = ARB_BURST_MAX
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [N-1:0]               req_i,
  input  logic [N-1:0][WIDTH-1:0]    din_i,
  output logic [N-1:0]               rdy_o,
  output logic                       fifo_wr_o,
  output logic [WIDTH-1:0]           fifo_din_o,
  input  logic                       fifo_full_i,
  output logic [$clog2(N)-1:0]       grant_id_o,
  output logic                       busy_o
);

  localparam int GW = $clog2(N);
  localparam int CW = cnt_width(BURST_MAX);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic          in_grant;
  logic          req_g;
  logic          xfer;
  logic          last_beat;
  logic [GW-1:0] next_ptr;

  rr_pick #(
    .N  (N),
    .PW (GW)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign in_grant  = (state_q == GRANT);
  assign req_g     = req_i[grant_q];
  // A beat presented while reset is asserted must not reach the FIFO.
  assign xfer      = in_grant && rstn_i && req_g && !fifo_full_i;
  assign last_beat = (beat_cnt_q == CW'(BURST_MAX - 1));
  assign next_ptr  = (grant_q == GW'(N - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    rdy_o = '0;
    if (in_grant && rstn_i) begin
      rdy_o[grant_q] = !fifo_full_i;
    end
  end

  assign fifo_wr_o  = xfer;
  assign fifo_din_o = din_i[grant_q];
  assign grant_id_o = grant_q;
  assign busy_o     = in_grant;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!req_g) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (xfer) begin
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
